// File: rtl/rx_arb_pkg.sv
// Shared types and widths for the RX stream arbiter.
package rx_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  localparam int unsigned N_CH_DEFAULT = 4;
  localparam int unsigned CH_IDX_W     = $clog2(N_CH_DEFAULT);
  localparam int unsigned BURST_CNT_W  = 8;
  localparam int unsigned WORD_CNT_W   = 16;

  // Channel index width for an arbitrary channel count, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_stream_arbiter_rr_pointer_search.sv
// Masked round-robin priority search: first set request at or above the pointer, wrapping.
module rr_pointer_search
  import rx_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = CH_IDX_W
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  always_comb begin : search
    int unsigned cand;
    logic        found;
    found = 1'b0;
    cand  = 0;
    idx_o = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(ptr_i) + k) % NumReq;
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IdxW-1:0];
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Round-robin merge of per-channel RX FIFOs into one stream with bounded bursts.
// Optional per-channel word counters are built when RX_ARB_WORD_CNT_EN is defined.
module rx_stream_arbiter
  import rx_arb_pkg::*;
#(
  parameter int unsigned  N_CH      = 4,
  parameter int unsigned  DATA_W    = 32,
  parameter int unsigned  MAX_BURST = 16,
  localparam int unsigned ChIdxW    = idx_width(N_CH)
) (
  input  logic                     CLK,
  input  logic                     RESETB,
  input  logic [N_CH-1:0]          CH_EN,
  input  logic [N_CH-1:0]          CH_EMPTY,
  input  logic [N_CH*DATA_W-1:0]   CH_DATA,
  output logic [N_CH-1:0]          CH_READ,
  input  logic                     ARB_READY_IN,
  output logic                     ARB_WRITE_OUT,
  output logic [DATA_W-1:0]        ARB_DATA_OUT,
  output logic [ChIdxW-1:0]        GRANT_OUT,
`ifdef RX_ARB_WORD_CNT_EN
  input  logic                     CNT_CLR,
  output logic [N_CH*WORD_CNT_W-1:0] CH_WORD_CNT,
`endif
  output logic                     BUSY
);

  arb_state_e             state_q, state_d;
  logic [ChIdxW-1:0]      grant_q, grant_d;
  logic [ChIdxW-1:0]      ptr_q, ptr_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;
  logic                   wr_q, wr_d;
  logic [DATA_W-1:0]      data_q, data_d;

  logic [N_CH-1:0]        req;
  logic                   found;
  logic [ChIdxW-1:0]      found_idx;
  logic                   head_empty;
  logic                   pop;
  logic                   burst_last;
  logic [DATA_W-1:0]      head_data;

  // CH_EN only matters at arbitration; the granted channel ignores it.
  assign req = CH_EN & ~CH_EMPTY;

  rr_pointer_search #(
    .NumReq(N_CH),
    .IdxW  (ChIdxW)
  ) u_search (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .found_o(found),
    .idx_o  (found_idx)
  );

  assign head_empty = CH_EMPTY[grant_q];
  assign head_data  = CH_DATA[32'(grant_q)*DATA_W +: DATA_W];
  assign pop        = (state_q == StGrant) && !head_empty && (!wr_q || ARB_READY_IN);
  assign burst_last = (burst_q == BURST_CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    wr_d    = wr_q;
    data_d  = data_q;
    CH_READ = '0;
    if (pop) begin
      CH_READ[grant_q] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = found_idx;
          burst_d = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (pop) begin
          burst_d = burst_q + 1'b1;
        end
        if ((pop && burst_last) || head_empty) begin
          state_d = StIdle;
          ptr_d   = (grant_q == ChIdxW'(N_CH - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Single-entry output register: refill on pop, drain when downstream takes it.
    if (pop) begin
      wr_d   = 1'b1;
      data_d = head_data;
    end else if (ARB_READY_IN) begin
      wr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

  assign ARB_WRITE_OUT = wr_q;
  assign ARB_DATA_OUT  = data_q;
  assign GRANT_OUT     = grant_q;
  assign BUSY          = (state_q == StGrant) || wr_q;

`ifdef RX_ARB_WORD_CNT_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_cnt
    logic [WORD_CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a simultaneous pop; count saturates instead of wrapping.
    always_comb begin
      cnt_d = cnt_q;
      if (CNT_CLR) begin
        cnt_d = '0;
      end else if (CH_READ[i] && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign CH_WORD_CNT[i*WORD_CNT_W +: WORD_CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter: FIFO emulation, burst-level model, directed tests.
module tb_rx_stream_arbiter;

  localparam int unsigned NCh = 4;
  localparam int unsigned Dw  = 32;
  localparam int unsigned Mb  = 16;

  logic              CLK = 1'b0;
  logic              RESETB;
  logic [NCh-1:0]    CH_EN;
  logic [NCh-1:0]    CH_EMPTY;
  logic [NCh*Dw-1:0] CH_DATA;
  logic [NCh-1:0]    CH_READ;
  logic              ARB_READY_IN;
  logic              ARB_WRITE_OUT;
  logic [Dw-1:0]     ARB_DATA_OUT;
  logic [1:0]        GRANT_OUT;
  logic              BUSY;
`ifdef RX_ARB_WORD_CNT_EN
  logic              CNT_CLR;
  logic [NCh*16-1:0] CH_WORD_CNT;
`endif

  rx_stream_arbiter #(
    .N_CH     (NCh),
    .DATA_W   (Dw),
    .MAX_BURST(Mb)
  ) dut (
    .CLK          (CLK),
    .RESETB       (RESETB),
    .CH_EN        (CH_EN),
    .CH_EMPTY     (CH_EMPTY),
    .CH_DATA      (CH_DATA),
    .CH_READ      (CH_READ),
    .ARB_READY_IN (ARB_READY_IN),
    .ARB_WRITE_OUT(ARB_WRITE_OUT),
    .ARB_DATA_OUT (ARB_DATA_OUT),
    .GRANT_OUT    (GRANT_OUT),
`ifdef RX_ARB_WORD_CNT_EN
    .CNT_CLR      (CNT_CLR),
    .CH_WORD_CNT  (CH_WORD_CNT),
`endif
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  logic [31:0] fifo_q[NCh][$];
  logic [31:0] exp_q[$];
  logic [NCh-1:0] rd_pend = '0;
  int checks = 0;
  int errors = 0;
  int serial = 0;
  int m_ptr = 0;
  int acc_total = 0;
  int rr_acc = 0;
  int rr_low = 0;
  bit in_rr = 1'b0;
  bit rr_started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void drive_heads();
    for (int i = 0; i < NCh; i++) begin
      CH_EMPTY[i] = (fifo_q[i].size() == 0);
      CH_DATA[i*Dw +: Dw] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endfunction

  // Word tag: channel in the top nibble, global serial below, so order and duplicates show.
  task automatic load(input int ch, input int n);
    for (int j = 0; j < n; j++) begin
      fifo_q[ch].push_back({4'(ch), 28'(serial)});
      serial++;
    end
    drive_heads();
  endtask

  // Burst-level model: from the pointer, grant the first enabled channel with data,
  // take min(Mb, backlog) words, move the pointer past it, repeat until nothing is eligible.
  function automatic void predict(input logic [NCh-1:0] en);
    int cnt[NCh];
    int pos[NCh];
    int g;
    int n;
    bit hit;
    for (int i = 0; i < NCh; i++) begin
      cnt[i] = fifo_q[i].size();
      pos[i] = 0;
    end
    do begin
      hit = 1'b0;
      g   = 0;
      for (int k = 0; k < NCh; k++) begin
        int c;
        c = (m_ptr + k) % NCh;
        if (!hit && en[c] && cnt[c] > 0) begin
          hit = 1'b1;
          g   = c;
        end
      end
      if (hit) begin
        n = (cnt[g] < Mb) ? cnt[g] : Mb;
        for (int j = 0; j < n; j++) exp_q.push_back(fifo_q[g][pos[g] + j]);
        pos[g] += n;
        cnt[g] -= n;
        m_ptr = (g + 1) % NCh;
      end
    end while (hit);
  endfunction

  // Compare process: outputs sampled mid-cycle, away from the active edge.
  always @(negedge CLK) begin
    rd_pend = RESETB ? CH_READ : '0;
    if (RESETB) begin
      if (CH_READ != '0) check("read_onehot", 32'($onehot(CH_READ)), 32'd1);
      if (ARB_WRITE_OUT && !ARB_READY_IN) check("stall_no_read", 32'(CH_READ), 32'd0);
      if (ARB_WRITE_OUT && ARB_READY_IN) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word actual=%h required=none at %0t", ARB_DATA_OUT, $time);
        end else begin
          check("word", ARB_DATA_OUT, exp_q.pop_front());
        end
        acc_total++;
        if (in_rr) begin
          rr_acc++;
          rr_started = 1'b1;
        end
      end else if (in_rr && rr_started && exp_q.size() != 0) begin
        rr_low++;
      end
    end
  end

  // FIFO emulation: a pop seen before the edge removes the head just after it.
  always @(posedge CLK) begin
    logic [NCh-1:0] rd;
    rd = RESETB ? rd_pend : '0;
    #1;
    for (int i = 0; i < NCh; i++) begin
      if (rd[i]) begin
        if (fifo_q[i].size() == 0) check("read_of_empty", 32'(i), 32'hFFFF_FFFF);
        else void'(fifo_q[i].pop_front());
      end
    end
    drive_heads();
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || BUSY) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_read"}, 32'(CH_READ), 32'd0);
    check({name, "_write"}, 32'(ARB_WRITE_OUT), 32'd0);
    check({name, "_data"}, ARB_DATA_OUT, 32'd0);
    check({name, "_grant"}, 32'(GRANT_OUT), 32'd0);
    check({name, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    tick();
    RESETB = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    @(posedge CLK);
    tick();
    RESETB = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run;
    int k;
    int acc0;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    RESETB       = 1'b1;
    CH_EN        = '0;
    ARB_READY_IN = 1'b1;
`ifdef RX_ARB_WORD_CNT_EN
    CNT_CLR      = 1'b0;
`endif
    drive_heads();
    #3;
    RESETB = 1'b0;
    #1;
    check_outputs_zero("reset");
    @(posedge CLK);
    tick();
    RESETB = 1'b1;

    // Empty mid-burst and mask: ch0 drains after 3, disabled ch1 skipped, ch3 next.
    step();
    CH_EN = 4'b1001;
    load(0, 3);
    load(1, 5);
    load(3, 20);
    predict(CH_EN);
    check("model_mask_len", 32'(exp_q.size()), 32'd23);
    check("model_mask_w3", 32'(exp_q[3][31:28]), 32'd3);
    wait_idle("mask", 200);
    check("mask_ch1_untouched", 32'(fifo_q[1].size()), 32'd5);
    fifo_q[1].delete();
    drive_heads();

    // Single channel ch2, 5 words: read one cycle after detect, word one cycle later.
    step();
    CH_EN = 4'b0100;
    load(2, 5);
    predict(CH_EN);
    tick();
    check("lat_detect_read", 32'(CH_READ), 32'd0);
    tick();
    check("lat_read", 32'(CH_READ), 32'b0100);
    check("grant_ch2", 32'(GRANT_OUT), 32'd2);
    tick();
    check("lat_write", 32'(ARB_WRITE_OUT), 32'd1);
    check("first_word_ch2", ARB_DATA_OUT, 32'h2000_001C);
    run = 0;
    for (int j = 0; j < 20; j++) begin
      if (ARB_WRITE_OUT) run++;
      else if (run > 0) break;
      tick();
    end
    check("ch2_run", 32'(run), 32'd5);
    wait_idle("single", 50);

    // Pointer left at 3: with ch0 and ch3 both ready, ch3 wins.
    step();
    CH_EN = 4'b1111;
    load(0, 1);
    load(3, 1);
    predict(CH_EN);
    check("model_ptr3", 32'(exp_q[0][31:28]), 32'd3);
    tick();
    tick();
    check("ptr3_read", 32'(CH_READ), 32'b1000);
    wait_idle("probe", 50);

    // Back-pressure during a ch1 burst.
    step();
    load(1, 10);
    predict(CH_EN);
    acc0 = acc_total;
    k = 0;
    while ((exp_q.size() != 0 || BUSY) && k < 200) begin
      step();
      ARB_READY_IN = pat[k % 4];
      k++;
    end
    step();
    ARB_READY_IN = 1'b1;
    wait_idle("bp", 50);
    check("bp_count", 32'(acc_total - acc0), 32'd10);

    // Async reset mid-burst with a word held in the output register.
    step();
    load(0, 10);
    load(1, 3);
    predict(CH_EN);
    k = 0;
    while (!ARB_WRITE_OUT && k < 10) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("rst_pre_write", 32'(ARB_WRITE_OUT), 32'd1);
    #1;
    RESETB = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    exp_q.delete();
    m_ptr = 0;
    @(posedge CLK);
    tick();
    RESETB = 1'b1;
    predict(CH_EN);
    check("model_rst_first", 32'(exp_q[0][31:28]), 32'd0);
    tick();
    check("rst_restart_ch0", 32'(CH_READ), 32'b0001);
    wait_idle("rst", 100);

    // Round-robin: 4 x 40 words -> two rounds of 16, one round of 8.
    do_reset();
    step();
    for (int c = 0; c < NCh; c++) load(c, 40);
    predict(CH_EN);
    check("model_rr_len", 32'(exp_q.size()), 32'd160);
    check("model_rr_w16", 32'(exp_q[16][31:28]), 32'd1);
    check("model_rr_w128", 32'(exp_q[128][31:28]), 32'd0);
    check("model_rr_w152", 32'(exp_q[152][31:28]), 32'd3);
    in_rr = 1'b1;
    wait_idle("rr", 400);
    in_rr = 1'b0;
    check("rr_total", 32'(rr_acc), 32'd160);
    // One idle cycle after each full burst; bursts ended by an empty FIFO cost two.
    check("rr_bubbles", 32'(rr_low), 32'd14);

`ifdef RX_ARB_WORD_CNT_EN
    step();
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    for (int i = 0; i < NCh; i++) check("cnt_clr_a", 32'(CH_WORD_CNT[i*16 +: 16]), 32'd0);
    CH_EN = 4'b0010;
    load(1, 65600);
    predict(CH_EN);
    wait_idle("cnt", 80000);
    check("cnt_sat_ch1", 32'(CH_WORD_CNT[31:16]), 32'h0000_FFFF);
    check("cnt_ch0", 32'(CH_WORD_CNT[15:0]), 32'd0);
    step();
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    for (int i = 0; i < NCh; i++) check("cnt_clr_b", 32'(CH_WORD_CNT[i*16 +: 16]), 32'd0);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
